// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int DEF_MEM_BYTES = 2048;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    LATCH,
    RESP
  } lsu_state_t;

  // Request attributes kept for the whole transaction
  typedef struct packed {
    logic store;
    logic is_byte;
    logic is_signed;
  } lsu_req_t;

endpackage

// File: rtl/lsu_extend.sv
// Load result formatting: word passthrough, byte sign/zero extension.
module lsu_extend (
  input  logic [15:0] raw,
  input  logic        is_byte,
  input  logic        is_signed,
  output logic [15:0] ext
);

  assign ext = is_byte ? {{8{is_signed & raw[7]}}, raw[7:0]} : raw;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator driving a registered byte-addressed memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES   = DEF_MEM_BYTES,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        mem_rd,
  output logic        mem_wn,
  output logic [15:0] mem_address,
  output logic [1:0]  mem_mode,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data
);

  localparam logic [16:0] LIMIT = 17'(MEM_BYTES);

  lsu_state_t  state, state_d;
  lsu_req_t    req_q, req_d;
  logic        resp_valid_d, resp_err_d, mem_rd_d, mem_wn_d;
  logic [15:0] resp_data_d, mem_address_d, mem_write_data_d;
  logic [1:0]  mem_mode_d;
  logic [15:0] ext;
  logic [16:0] addr_x;
  logic        acc_err;

  assign req_ready = (state == IDLE);

  // 17-bit compare so addr+1 cannot wrap past the top of the 16-bit space
  assign addr_x  = {1'b0, req_addr};
  assign acc_err = (addr_x >= LIMIT)
                 || (!req_byte && ((addr_x + 17'd1) >= LIMIT))
                 || (!req_byte && req_addr[0] && ALIGN_CHECK);

  lsu_extend u_extend (
    .raw       (mem_read_data),
    .is_byte   (req_q.is_byte),
    .is_signed (req_q.is_signed),
    .ext       (ext)
  );

  always_comb begin
    state_d          = state;
    req_d            = req_q;
    resp_valid_d     = resp_valid;
    resp_data_d      = resp_data;
    resp_err_d       = resp_err;
    mem_rd_d         = 1'b0;
    mem_wn_d         = 1'b0;
    mem_address_d    = mem_address;
    mem_mode_d       = mem_mode;
    mem_write_data_d = mem_write_data;
    case (state)
      IDLE: begin
        if (req_valid) begin
          req_d            = '{store: req_store, is_byte: req_byte, is_signed: req_signed};
          mem_address_d    = req_addr;
          mem_mode_d       = req_byte ? MODE_BYTE : MODE_WORD;
          mem_write_data_d = req_byte ? {8'h00, req_wdata[7:0]} : req_wdata;
          if (acc_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 16'h0000;
          end else if (req_store) begin
            state_d  = WRITE;
            mem_wn_d = 1'b1;
          end else begin
            state_d  = READ;
            mem_rd_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = 16'h0000;
      end
      READ: state_d = LATCH;
      // Memory output registered at the end of READ is valid throughout LATCH
      LATCH: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = ext;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_data_d  = 16'h0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_q          <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= 16'h0000;
      resp_err       <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wn         <= 1'b0;
      mem_address    <= 16'h0000;
      mem_mode       <= MODE_WORD;
      mem_write_data <= 16'h0000;
    end else begin
      state          <= state_d;
      req_q          <= req_d;
      resp_valid     <= resp_valid_d;
      resp_data      <= resp_data_d;
      resp_err       <= resp_err_d;
      mem_rd         <= mem_rd_d;
      mem_wn         <= mem_wn_d;
      mem_address    <= mem_address_d;
      mem_mode       <= mem_mode_d;
      mem_write_data <= mem_write_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a big-endian byte memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready, resp_valid, resp_err, mem_rd, mem_wn;
  logic [15:0] resp_data, mem_address, mem_write_data;
  logic [1:0]  mem_mode;
  logic [15:0] mem_read_data = '0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wn_cnt = 0;
  logic [15:0] wn_addr = '0, wn_data = '0;
  logic [1:0]  wn_mode = '0;
  logic [16:0] exp_q[$];
  logic [7:0]  mem [0:2047];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .mem_rd(mem_rd), .mem_wn(mem_wn),
    .mem_address(mem_address), .mem_mode(mem_mode),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: commits writes on negedge, registers read data on posedge
  initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

  always @(negedge clk) begin
    if (mem_wn) begin
      if (mem_mode == 2'b01) mem[mem_address[10:0]] = mem_write_data[7:0];
      else begin
        mem[mem_address[10:0]]         = mem_write_data[15:8];
        mem[mem_address[10:0] + 11'd1] = mem_write_data[7:0];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_rd) begin
      if (mem_mode == 2'b01) mem_read_data <= {8'h00, mem[mem_address[10:0]]};
      else mem_read_data <= {mem[mem_address[10:0]], mem[mem_address[10:0] + 11'd1]};
    end
  end

  // Strobe tracker
  always @(negedge clk) begin
    if (mem_rd && mem_wn) chk("rd_wn_exclusive", 32'd1, 32'd0);
    if (mem_rd) rd_cnt++;
    if (mem_wn) begin
      wn_cnt++;
      wn_addr = mem_address;
      wn_mode = mem_mode;
      wn_data = mem_write_data;
    end
  end

  // Response monitor: pops one expectation per handshake
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h err %b expected none", resp_data, resp_err);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", {16'h0, resp_data}, {16'h0, e[15:0]});
        chk("resp_err", {31'h0, resp_err}, {31'h0, e[16]});
      end
    end
  end

  task automatic do_req(input logic st, input logic bt, input logic sg,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] ed, input logic ee,
                        input int elat, input int erd, input int ewn, input int hold);
    int lat, rd0, wn0;
    @(posedge clk); #1;
    rd0 = rd_cnt; wn0 = wn_cnt;
    req_valid = 1'b1; req_store = st; req_byte = bt; req_signed = sg;
    req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    exp_q.push_back({ee, ed});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, resp_valid}, 32'd1);
      chk("hold_data", {16'h0, resp_data}, {16'h0, ed});
      chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rd_strobes", rd_cnt - rd0, erd);
    chk("wn_strobes", wn_cnt - wn0, ewn);
    chk("idle_after", {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp", {15'h0, resp_err, resp_data}, 32'd0);
    chk("rst_mem_strobes", {30'h0, mem_rd, mem_wn}, 32'd0);
    chk("rst_mem_bus", {mem_address, mem_write_data}, 32'd0);
    chk("rst_mem_mode", {30'h0, mem_mode}, 32'd0);
    rst_n = 1'b1;

    // Word store then word load
    do_req(1, 0, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 1, 0, 1, 0);
    chk("st_addr", {16'h0, wn_addr}, 32'h10);
    chk("st_mode", {30'h0, wn_mode}, 32'h0);
    chk("st_data", {16'h0, wn_data}, 32'hBEEF);
    do_req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 1, 0, 0);
    // Byte loads
    do_req(0, 1, 1, 16'h0010, 16'h0000, 16'hFFBE, 0, 2, 1, 0, 0);
    do_req(0, 1, 0, 16'h0010, 16'h0000, 16'h00BE, 0, 2, 1, 0, 0);
    do_req(0, 1, 0, 16'h0011, 16'h0000, 16'h00EF, 0, 2, 1, 0, 0);
    do_req(0, 1, 1, 16'h0011, 16'h0000, 16'hFFEF, 0, 2, 1, 0, 0);
    // Byte store then word load
    do_req(1, 1, 0, 16'h0020, 16'h1234, 16'h0000, 0, 1, 0, 1, 0);
    chk("bst_mode", {30'h0, wn_mode}, 32'h1);
    chk("bst_data", {16'h0, wn_data}, 32'h0034);
    do_req(0, 0, 0, 16'h0020, 16'h0000, 16'h3400, 0, 2, 1, 0, 0);
    // Top byte is legal for byte access
    do_req(1, 1, 0, 16'h07FF, 16'h0080, 16'h0000, 0, 1, 0, 1, 0);
    do_req(0, 1, 1, 16'h07FF, 16'h0000, 16'hFF80, 0, 2, 1, 0, 0);
    // Errors
    do_req(0, 0, 0, 16'h07FF, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);
    do_req(0, 1, 0, 16'h0800, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);
    do_req(1, 0, 0, 16'h0003, 16'h5555, 16'h0000, 1, 0, 0, 0, 0);
    do_req(1, 1, 0, 16'hFFFF, 16'h5555, 16'h0000, 1, 0, 0, 0, 0);
    do_req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 1, 0, 0);
    // Backpressure
    do_req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 1, 0, 5);

    // Reset during READ
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_rd", {31'h0, mem_rd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_drop", {31'h0, mem_rd}, 32'd0);
    chk("async_req_ready", {31'h0, req_ready}, 32'd1);
    #3 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_resp_after_rst", {31'h0, resp_valid}, 32'd0);
    end
    do_req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 1, 0, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
